// File: rtl/mask_frame_if.sv
// mask_frame_if: pixel, config, mask-buffer and frame-handoff signals of mask_frame_ctrl
interface mask_frame_if;
  logic        pixel_valid_in;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        mask_bit_in;
  logic        mask_valid_in;
  logic        cfg_we;
  logic [7:0]  cfg_hue_lo;
  logic [7:0]  cfg_hue_hi;
  logic [7:0]  hue_lo;
  logic [7:0]  hue_hi;
  logic        wr_en;
  logic        wr_bank;
  logic [16:0] wr_addr;
  logic        wr_data;
  logic        frame_ready;
  logic        rd_bank;
  logic        frame_ack;
  logic [16:0] green_count;
  logic [7:0]  frames_dropped;

  modport slave (
    input  pixel_valid_in, hcount, vcount, mask_bit_in, mask_valid_in,
           cfg_we, cfg_hue_lo, cfg_hue_hi, frame_ack,
    output hue_lo, hue_hi, wr_en, wr_bank, wr_addr, wr_data,
           frame_ready, rd_bank, green_count, frames_dropped
  );

  modport master (
    output pixel_valid_in, hcount, vcount, mask_bit_in, mask_valid_in,
           cfg_we, cfg_hue_lo, cfg_hue_hi, frame_ack,
    input  hue_lo, hue_hi, wr_en, wr_bank, wr_addr, wr_data,
           frame_ready, rd_bank, green_count, frames_dropped
  );
endinterface

// File: rtl/mask_frame_ctrl.sv
// mask_frame_ctrl: mask frame sequencer with ping-pong buffers; MASK_STATS_EN enables green/drop statistics
module mask_frame_ctrl #(
  parameter int         PIPE_LAT    = 24,
  parameter logic [7:0] HUE_LO_INIT = 8'd60,
  parameter logic [7:0] HUE_HI_INIT = 8'd180
) (
  input logic       clk,
  input logic       reset,
  mask_frame_if.slave bus
);
  localparam int FW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH, HANDOFF} state_t;

  state_t state, state_nx;
  logic [7:0] sh_lo, sh_hi, hue_lo, hue_hi;
  logic [PIPE_LAT-1:0] dl_v;
  logic [16:0] dl_a [PIPE_LAT];
  logic [FW-1:0] fl_cnt;
  logic wr_en, wr_bank, wr_data, frame_ready;
  logic [16:0] wr_addr, v17, addr;
  logic origin, last, start, push, fl_done, wv, swap;

  always_comb begin
    v17 = 17'(bus.vcount);
    addr = (v17 << 8) + (v17 << 6) + 17'(bus.hcount);
    origin = bus.pixel_valid_in && bus.hcount == 11'd0 && bus.vcount == 10'd0;
    last = bus.pixel_valid_in && bus.hcount == 11'd319 && bus.vcount == 10'd239;
    start = origin && (state == IDLE || state == ACTIVE);
    push = bus.pixel_valid_in && (state == ACTIVE || start) && bus.hcount < 11'd320 && bus.vcount < 10'd240;
    fl_done = fl_cnt == FW'(PIPE_LAT - 1);
    wv = bus.mask_valid_in && dl_v[PIPE_LAT-1];
    swap = state == HANDOFF && (!frame_ready || bus.frame_ack);
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ACTIVE;
      ACTIVE:  if (last) state_nx = FLUSH;
      FLUSH:   if (fl_done) state_nx = HANDOFF;
      default: state_nx = IDLE;
    endcase
  end

  // Delay line shifts every cycle so its output lines up with mask_valid_in.
  always_ff @(posedge clk) begin
    dl_a[0] <= addr;
    for (int i = 1; i < PIPE_LAT; i++) dl_a[i] <= dl_a[i-1];
    if (reset) begin
      state <= IDLE;
      sh_lo <= HUE_LO_INIT;
      sh_hi <= HUE_HI_INIT;
      hue_lo <= HUE_LO_INIT;
      hue_hi <= HUE_HI_INIT;
      dl_v <= '0;
      fl_cnt <= '0;
      wr_en <= 1'b0;
      wr_bank <= 1'b0;
      wr_addr <= '0;
      wr_data <= 1'b0;
      frame_ready <= 1'b0;
    end else begin
      state <= state_nx;
      if (bus.cfg_we) begin
        sh_lo <= bus.cfg_hue_lo;
        sh_hi <= bus.cfg_hue_hi;
      end
      if (start) begin
        hue_lo <= sh_lo;
        hue_hi <= sh_hi;
      end
      dl_v <= PIPE_LAT'({dl_v, push});
      fl_cnt <= state == FLUSH ? fl_cnt + FW'(1) : '0;
      wr_en <= wv;
      if (wv) begin
        wr_addr <= dl_a[PIPE_LAT-1];
        wr_data <= bus.mask_bit_in;
      end
      frame_ready <= swap || (frame_ready && !bus.frame_ack);
      if (swap) wr_bank <= ~wr_bank;
    end
  end

`ifdef MASK_STATS_EN
  logic [16:0] frame_cnt, green_q;
  logic [7:0] drop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      green_q <= '0;
      drop_q <= '0;
    end else begin
      frame_cnt <= start ? '0 : frame_cnt + 17'(wv && bus.mask_bit_in);
      if (swap) green_q <= frame_cnt;
      if (state == HANDOFF && !swap && drop_q != 8'hff) drop_q <= drop_q + 8'd1;
    end
  end

  assign bus.green_count = green_q;
  assign bus.frames_dropped = drop_q;
`else
  assign bus.green_count = '0;
  assign bus.frames_dropped = '0;
`endif

  assign bus.hue_lo = hue_lo;
  assign bus.hue_hi = hue_hi;
  assign bus.wr_en = wr_en;
  assign bus.wr_bank = wr_bank;
  assign bus.wr_addr = wr_addr;
  assign bus.wr_data = wr_data;
  assign bus.frame_ready = frame_ready;
  assign bus.rd_bank = ~wr_bank;
endmodule

// File: tb/tb_mask_frame_ctrl.sv
// tb_mask_frame_ctrl: scoreboard bench for mask_frame_ctrl with a latency-matched datapath model
module tb_mask_frame_ctrl;
  localparam int PL = 24;
`ifdef MASK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mask_frame_if bus();
  mask_frame_ctrl #(.PIPE_LAT(PL)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Stand-in for the RGB->HSV->threshold datapath: fixed PL-cycle latency.
  logic px_bit = 1'b0;
  logic [PL-1:0] mv_sr = '0;
  logic [PL-1:0] mb_sr = '0;
  always @(posedge clk) begin
    mv_sr <= {mv_sr[PL-2:0], bus.pixel_valid_in};
    mb_sr <= {mb_sr[PL-2:0], px_bit};
  end
  assign bus.mask_valid_in = mv_sr[PL-1];
  assign bus.mask_bit_in = mb_sr[PL-1];

  logic [18:0] sb[$];
  logic [18:0] mon_exp;
  int checks = 0, fails = 0, n_wr = 0, fr_green = 0;
  logic in_frame = 1'b0, exp_bank = 1'b0;

  task automatic monitor;
    forever begin
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
        n_wr++;
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL write_unexpected: got bank=%0d addr=%0d data=%0d, expected no write", bus.wr_bank, bus.wr_addr, bus.wr_data);
        end else begin
          mon_exp = sb.pop_front();
          if ({bus.wr_bank, bus.wr_addr, bus.wr_data} !== mon_exp) begin
            fails++;
            $display("FAIL write: got bank=%0d addr=%0d data=%0d, expected bank=%0d addr=%0d data=%0d",
                     bus.wr_bank, bus.wr_addr, bus.wr_data, mon_exp[18], mon_exp[17:1], mon_exp[0]);
          end
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pix(input int h, input int v, input logic b);
    bus.pixel_valid_in = 1'b1;
    bus.hcount = 11'(h);
    bus.vcount = 10'(v);
    px_bit = b;
    if (h == 0 && v == 0) begin
      in_frame = 1'b1;
      fr_green = 0;
    end
    if (in_frame && h < 320 && v < 240) begin
      sb.push_back({exp_bank, 17'(v * 320 + h), b});
      fr_green += int'(b);
    end
    if (h == 319 && v == 239) in_frame = 1'b0;
    @(posedge clk);
    #1;
    bus.pixel_valid_in = 1'b0;
  endtask

  task automatic body(input int n);
    int h, v;
    for (int i = 0; i < n; i++) begin
      h = int'($urandom_range(0, 335));
      v = int'($urandom_range(0, 250));
      if ((h == 0 && v == 0) || (h == 319 && v == 239)) h = 7;
      pix(h, v, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset;
    bus.pixel_valid_in = 1'b0;
    bus.hcount = '0;
    bus.vcount = '0;
    bus.cfg_we = 1'b0;
    bus.cfg_hue_lo = '0;
    bus.cfg_hue_hi = '0;
    bus.frame_ack = 1'b0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(1);
    checks++;
    if ({bus.hue_lo, bus.hue_hi} !== {8'd60, 8'd180}) begin
      fails++;
      $display("FAIL reset_hue: got %0d/%0d, expected 60/180", bus.hue_lo, bus.hue_hi);
    end
    checks++;
    if ({bus.wr_en, bus.wr_bank, bus.rd_bank, bus.wr_data} !== 4'b0010) begin
      fails++;
      $display("FAIL reset_wr: got en/bank/rd/data=%b, expected 0010", {bus.wr_en, bus.wr_bank, bus.rd_bank, bus.wr_data});
    end
    checks++;
    if (bus.wr_addr !== 17'd0) begin
      fails++;
      $display("FAIL reset_addr: got %0d, expected 0", bus.wr_addr);
    end
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready: got %b, expected 0", bus.frame_ready);
    end
    checks++;
    if ({bus.green_count, bus.frames_dropped} !== 25'd0) begin
      fails++;
      $display("FAIL reset_stats: got green=%0d dropped=%0d, expected 0/0", bus.green_count, bus.frames_dropped);
    end
  endtask

  task automatic test_full_frame;
    int n0;
    n0 = n_wr;
    for (int v = 0; v < 240; v++)
      for (int h = 0; h < 320; h++) pix(h, v, h % 2 == 0);
    idle(PL);
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      fails++;
      $display("FAIL full_ready_early: got %b at +%0d, expected 0", bus.frame_ready, PL + 1);
    end
    idle(1);
    checks++;
    if (bus.frame_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_ready_rise: got %b at +%0d, expected 1", bus.frame_ready, PL + 2);
    end
    exp_bank = 1'b1;
    checks++;
    if (n_wr - n0 != 76800 || sb.size() != 0) begin
      fails++;
      $display("FAIL full_writes: got %0d writes (%0d outstanding), expected 76800 (0)", n_wr - n0, sb.size());
    end
    checks++;
    if ({bus.wr_bank, bus.rd_bank} !== 2'b10) begin
      fails++;
      $display("FAIL full_banks: got wr/rd=%b, expected 10", {bus.wr_bank, bus.rd_bank});
    end
    checks++;
    if (bus.green_count !== (STATS ? 17'd38400 : 17'd0)) begin
      fails++;
      $display("FAIL full_green: got %0d, expected %0d", bus.green_count, STATS ? 38400 : 0);
    end
    checks++;
    if ({bus.hue_lo, bus.hue_hi} !== {8'd60, 8'd180}) begin
      fails++;
      $display("FAIL full_hue: got %0d/%0d, expected 60/180", bus.hue_lo, bus.hue_hi);
    end
  endtask

  task automatic test_drop;
    pix(0, 0, 1'b1);
    body(40);
    pix(319, 239, 1'b0);
    idle(PL + 1);
    checks++;
    if ({bus.frame_ready, bus.wr_bank, bus.rd_bank} !== 3'b110 || sb.size() != 0) begin
      fails++;
      $display("FAIL drop_state: got ready/wr/rd=%b outstanding=%0d, expected 110 and 0", {bus.frame_ready, bus.wr_bank, bus.rd_bank}, sb.size());
    end
    checks++;
    if (bus.frames_dropped !== (STATS ? 8'd1 : 8'd0)) begin
      fails++;
      $display("FAIL drop_count: got %0d, expected %0d", bus.frames_dropped, STATS ? 1 : 0);
    end
    checks++;
    if (bus.green_count !== (STATS ? 17'd38400 : 17'd0)) begin
      fails++;
      $display("FAIL drop_green_kept: got %0d, expected %0d", bus.green_count, STATS ? 38400 : 0);
    end
  endtask

  task automatic test_ack;
    bus.frame_ack = 1'b1;
    idle(1);
    bus.frame_ack = 1'b0;
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      fails++;
      $display("FAIL ack_clear: got ready=%b, expected 0", bus.frame_ready);
    end
    bus.frame_ack = 1'b1;
    idle(1);
    bus.frame_ack = 1'b0;
    checks++;
    if ({bus.frame_ready, bus.wr_bank} !== 2'b01) begin
      fails++;
      $display("FAIL ack_ignored: got ready/wr=%b, expected 01", {bus.frame_ready, bus.wr_bank});
    end
  endtask

  task automatic test_cfg;
    pix(0, 0, 1'b1);
    body(10);
    bus.cfg_we = 1'b1;
    bus.cfg_hue_lo = 8'd40;
    bus.cfg_hue_hi = 8'd100;
    pix(12, 34, 1'b1);
    bus.cfg_we = 1'b0;
    body(10);
    checks++;
    if ({bus.hue_lo, bus.hue_hi} !== {8'd60, 8'd180}) begin
      fails++;
      $display("FAIL cfg_mid: got %0d/%0d, expected 60/180", bus.hue_lo, bus.hue_hi);
    end
    pix(319, 239, 1'b1);
    idle(PL + 1);
    exp_bank = 1'b0;
    checks++;
    if ({bus.frame_ready, bus.wr_bank} !== 2'b10 || bus.green_count !== (STATS ? 17'(fr_green) : 17'd0)) begin
      fails++;
      $display("FAIL cfg_handoff: got ready/wr=%b green=%0d, expected 10 green=%0d", {bus.frame_ready, bus.wr_bank}, bus.green_count, STATS ? fr_green : 0);
    end
    checks++;
    if ({bus.hue_lo, bus.hue_hi} !== {8'd60, 8'd180}) begin
      fails++;
      $display("FAIL cfg_after_frame: got %0d/%0d, expected 60/180", bus.hue_lo, bus.hue_hi);
    end
    bus.frame_ack = 1'b1;
    idle(1);
    bus.frame_ack = 1'b0;
    pix(0, 0, 1'b0);
    checks++;
    if ({bus.hue_lo, bus.hue_hi} !== {8'd40, 8'd100}) begin
      fails++;
      $display("FAIL cfg_apply: got %0d/%0d, expected 40/100", bus.hue_lo, bus.hue_hi);
    end
    body(10);
    pix(319, 239, 1'b1);
    idle(PL + 1);
    exp_bank = 1'b1;
    checks++;
    if ({bus.frame_ready, bus.wr_bank} !== 2'b11 || bus.green_count !== (STATS ? 17'(fr_green) : 17'd0)) begin
      fails++;
      $display("FAIL cfg_second: got ready/wr=%b green=%0d, expected 11 green=%0d", {bus.frame_ready, bus.wr_bank}, bus.green_count, STATS ? fr_green : 0);
    end
  endtask

  task automatic test_truncated;
    bus.frame_ack = 1'b1;
    idle(1);
    bus.frame_ack = 1'b0;
    pix(0, 0, 1'b1);
    body(20);
    pix(200, 99, 1'b1);
    pix(0, 100, 1'b1);
    idle(PL + 2);
    checks++;
    if (bus.frame_ready !== 1'b0 || sb.size() != 0) begin
      fails++;
      $display("FAIL trunc_partial: got ready=%b outstanding=%0d, expected 0 and 0", bus.frame_ready, sb.size());
    end
    pix(0, 0, 1'b0);
    body(20);
    checks++;
    if (bus.frame_ready !== 1'b0) begin
      fails++;
      $display("FAIL trunc_restart: got ready=%b, expected 0", bus.frame_ready);
    end
    pix(319, 239, 1'b1);
    idle(PL + 1);
    exp_bank = 1'b0;
    checks++;
    if ({bus.frame_ready, bus.wr_bank} !== 2'b10 || bus.green_count !== (STATS ? 17'(fr_green) : 17'd0)) begin
      fails++;
      $display("FAIL trunc_handoff: got ready/wr=%b green=%0d, expected 10 green=%0d", {bus.frame_ready, bus.wr_bank}, bus.green_count, STATS ? fr_green : 0);
    end
  endtask

  task automatic test_ack_handoff;
    pix(0, 0, 1'b1);
    body(15);
    pix(319, 239, 1'b1);
    idle(PL);
    bus.frame_ack = 1'b1;
    idle(1);
    bus.frame_ack = 1'b0;
    exp_bank = 1'b1;
    checks++;
    if ({bus.frame_ready, bus.wr_bank, bus.rd_bank} !== 3'b110) begin
      fails++;
      $display("FAIL ackho_swap: got ready/wr/rd=%b, expected 110", {bus.frame_ready, bus.wr_bank, bus.rd_bank});
    end
    checks++;
    if (bus.frames_dropped !== (STATS ? 8'd1 : 8'd0) || bus.green_count !== (STATS ? 17'(fr_green) : 17'd0)) begin
      fails++;
      $display("FAIL ackho_stats: got dropped=%0d green=%0d, expected %0d/%0d", bus.frames_dropped, bus.green_count, STATS ? 1 : 0, STATS ? fr_green : 0);
    end
  endtask

  task automatic test_reset_mid;
    int n0;
    pix(0, 0, 1'b1);
    body(10);
    reset = 1'b1;
    pix(150, 120, 1'b1);
    reset = 1'b0;
    checks++;
    if ({bus.hue_lo, bus.hue_hi} !== {8'd60, 8'd180}) begin
      fails++;
      $display("FAIL rmid_hue: got %0d/%0d, expected 60/180", bus.hue_lo, bus.hue_hi);
    end
    checks++;
    if ({bus.wr_en, bus.wr_bank, bus.rd_bank, bus.wr_data, bus.frame_ready} !== 5'b00100 || bus.wr_addr !== 17'd0) begin
      fails++;
      $display("FAIL rmid_outs: got en/wr/rd/data/ready=%b addr=%0d, expected 00100 addr=0", {bus.wr_en, bus.wr_bank, bus.rd_bank, bus.wr_data, bus.frame_ready}, bus.wr_addr);
    end
    checks++;
    if ({bus.green_count, bus.frames_dropped} !== 25'd0) begin
      fails++;
      $display("FAIL rmid_stats: got green=%0d dropped=%0d, expected 0/0", bus.green_count, bus.frames_dropped);
    end
    sb.delete();
    in_frame = 1'b0;
    exp_bank = 1'b0;
    n0 = n_wr;
    idle(PL + 5);
    checks++;
    if (n_wr != n0) begin
      fails++;
      $display("FAIL rmid_quiet: got %0d writes, expected 0", n_wr - n0);
    end
    pix(0, 0, 1'b1);
    idle(PL - 1);
    checks++;
    if (n_wr != n0) begin
      fails++;
      $display("FAIL rmid_latency_early: got %0d writes, expected 0", n_wr - n0);
    end
    idle(2);
    checks++;
    if (n_wr != n0 + 1) begin
      fails++;
      $display("FAIL rmid_latency: got %0d writes, expected 1", n_wr - n0);
    end
    body(5);
    pix(319, 239, 1'b0);
    idle(PL + 1);
    exp_bank = 1'b1;
    checks++;
    if ({bus.frame_ready, bus.wr_bank} !== 2'b11 || sb.size() != 0 || bus.green_count !== (STATS ? 17'(fr_green) : 17'd0)) begin
      fails++;
      $display("FAIL rmid_frame: got ready/wr=%b outstanding=%0d green=%0d, expected 11 0 %0d", {bus.frame_ready, bus.wr_bank}, sb.size(), bus.green_count, STATS ? fr_green : 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_full_frame();
    test_drop();
    test_ack();
    test_cfg();
    test_truncated();
    test_ack_handoff();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
